cnt_seq: RTL

CNT_SEQ -- requirements
Module: cnt_seq

---
 rtl/cnt_seq_pkg.sv | 24 ++
 rtl/cntchunk.sv | 31 +++
 rtl/cnt_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg -- shared op/state encodings and default slice width for cnt_seq.
// Rev 1.0
`default_nettype none

package cnt_seq_pkg;

   localparam int DEF_CHUNK = 16;

   typedef enum logic [1:0] {
      OP_CLZ  = 2'b00,
      OP_CTZ  = 2'b01,
      OP_CPOP = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

`default_nettype wire

// File: rtl/cntchunk.sv
// cntchunk -- combinational leading-zero count, popcount and nonzero flag of one slice.
// Rev 1.0
`default_nettype none

module cntchunk
   import cnt_seq_pkg::*;
#(
   parameter int CHUNK = DEF_CHUNK,
   parameter int CW    = $clog2(CHUNK) + 1
) (
   input  logic [CHUNK-1:0] slice,
   output logic [CW-1:0]    lzc,
   output logic [CW-1:0]    pop,
   output logic             nz
);

   // Ascending scan: the highest set bit is the last one to write lzc.
   always_comb begin
      pop = '0;
      lzc = CW'(CHUNK);
      for (int i = 0; i < CHUNK; i++) begin
         pop = pop + CW'(slice[i]);
         if (slice[i]) lzc = CW'(CHUNK - 1 - i);
      end
   end

   assign nz = |slice;

endmodule

`default_nettype wire

// File: rtl/cnt_seq.sv
// cnt_seq -- multi-cycle clz/ctz/cpop unit, one CHUNK slice per cycle, MSB slice first.
// Rev 1.0; CNTSEQ_EARLYOUT_EN lets clz/ctz finish right after the first nonzero slice.
`default_nettype none

module cnt_seq
   import cnt_seq_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            ReqValid,
   output logic            ReqReady,
   input  logic [XLEN-1:0] A,
   input  logic [1:0]      Op,
   input  logic            W64,
   input  logic            Flush,
   output logic            RespValid,
   input  logic            RespReady,
   output logic [XLEN-1:0] CntResult,
   output logic            Busy
);

   localparam int NCHUNK = XLEN / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int ACCW   = $clog2(XLEN) + 1;
   localparam int CW     = $clog2(CHUNK) + 1;

   state_e            state;
   op_e               op_q;
   logic [XLEN-1:0]   opnd;
   logic [ACCW-1:0]   acc;
   logic [IDXW-1:0]   idx;
   logic              found;
   logic              ready_q;
   logic              resp_q;

   logic [XLEN-1:0]   rev_a;
   logic [XLEN-1:0]   eff;
   logic [CW-1:0]     lzc;
   logic [CW-1:0]     pop;
   logic              nz;
   logic              last;
   logic              finish;

   always_comb begin
      rev_a = '0;
      for (int i = 0; i < XLEN; i++) rev_a[i] = A[XLEN-1-i];
   end

   // Word ops pad the low half with ones so clz/ctz stop at 32 on an all-zero word.
   generate
      if (XLEN > 32) begin : g_w64
         logic [31:0] rev_lo;
         always_comb begin
            rev_lo = '0;
            for (int i = 0; i < 32; i++) rev_lo[i] = A[31-i];
         end
         always_comb begin
            case (op_e'(Op))
               OP_CLZ:  eff = W64 ? {A[31:0], {(XLEN-32){1'b1}}} : A;
               OP_CTZ:  eff = W64 ? {rev_lo, {(XLEN-32){1'b1}}} : rev_a;
               OP_CPOP: eff = W64 ? {{(XLEN-32){1'b0}}, A[31:0]} : A;
               default: eff = A;
            endcase
         end
      end else begin : g_w32
         logic unused_w64;
         assign unused_w64 = W64;
         always_comb begin
            case (op_e'(Op))
               OP_CTZ:  eff = rev_a;
               default: eff = A;
            endcase
         end
      end
   endgenerate

   cntchunk #(.CHUNK(CHUNK), .CW(CW)) u_chunk (
      .slice (opnd[XLEN-1 -: CHUNK]),
      .lzc   (lzc),
      .pop   (pop),
      .nz    (nz)
   );

   assign last = (idx == IDXW'(NCHUNK - 1));

`ifdef CNTSEQ_EARLYOUT_EN
   assign finish = last || (op_q == OP_RSVD) ||
                   ((op_q != OP_CPOP) && !found && nz);
`else
   assign finish = last || (op_q == OP_RSVD);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         op_q    <= OP_CLZ;
         opnd    <= '0;
         acc     <= '0;
         idx     <= '0;
         found   <= 1'b0;
         ready_q <= 1'b0;
         resp_q  <= 1'b0;
      end else if (Flush) begin
         state   <= ST_IDLE;
         ready_q <= 1'b1;
         resp_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               ready_q <= 1'b1;
               if (ReqValid && ready_q) begin
                  state   <= ST_RUN;
                  op_q    <= op_e'(Op);
                  opnd    <= eff;
                  acc     <= '0;
                  idx     <= '0;
                  found   <= 1'b0;
                  ready_q <= 1'b0;
               end
            end
            ST_RUN: begin
               case (op_q)
                  OP_CPOP: acc <= acc + ACCW'(pop);
                  OP_RSVD: acc <= '0;
                  default: begin
                     if (!found) begin
                        acc   <= acc + ACCW'(lzc);
                        found <= nz;
                     end
                  end
               endcase
               if (finish) begin
                  state  <= ST_DONE;
                  resp_q <= 1'b1;
               end else begin
                  idx  <= idx + 1'b1;
                  opnd <= opnd << CHUNK;
               end
            end
            ST_DONE: begin
               if (RespReady) begin
                  state   <= ST_IDLE;
                  resp_q  <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b0;
               resp_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ReqReady  = ready_q;
   assign RespValid = resp_q;
   assign Busy      = (state != ST_IDLE);
   assign CntResult = {{(XLEN-ACCW){1'b0}}, acc};

endmodule

`default_nettype wire
